// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the variable-latency imem handshake and
// presents one instruction plus its PC+2 to IF/ID until the hazard unit accepts it.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] imem_addr_o,
    output logic        imem_rd_o,
    input  logic        imem_done_i,
    input  logic [15:0] imem_data_i,
    input  logic        accept_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [15:0] if_instr_o,
    output logic [15:0] if_pc_plus2_o,
    output logic        if_bubble_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {StFetch, StHeld, StDrain, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] drain_q, drain_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc2_q, buf_pc2_d;

    logic [15:0] pc_plus2;
    logic [15:0] redirect_tgt;
    logic        valid;
    logic [15:0] instr_raw;

    assign pc_plus2     = pc_q + 16'd2;
    assign redirect_tgt = {redirect_pc_i[15:1], 1'b0};

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == 5'b00000;
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_d       = drain_q;
        buf_instr_d   = buf_instr_q;
        buf_pc2_d     = buf_pc2_q;
        imem_rd_o     = 1'b0;
        imem_addr_o   = pc_q;
        valid         = 1'b0;
        instr_raw     = NOP_INSTR;
        if_pc_plus2_o = pc_plus2;
        halted_o      = 1'b0;

        if (rst_i) begin
            if_pc_plus2_o = 16'h0000;
        end else begin
            unique case (state_q)
                StFetch: begin
                    imem_rd_o = 1'b1;
                    if (redirect_i) begin
                        pc_d = redirect_tgt;
                        // Abandoned request must still complete at its original address.
                        if (!imem_done_i) begin
                            drain_d = pc_q;
                            state_d = StDrain;
                        end
                    end else if (imem_done_i) begin
                        valid     = 1'b1;
                        instr_raw = imem_data_i;
                        if (accept_i) begin
                            if (is_halt(imem_data_i)) state_d = StHalted;
                            else                      pc_d    = pc_plus2;
                        end else begin
                            buf_instr_d = imem_data_i;
                            buf_pc2_d   = pc_plus2;
                            state_d     = StHeld;
                        end
                    end
                end
                StHeld: begin
                    if_pc_plus2_o = buf_pc2_q;
                    if (redirect_i) begin
                        pc_d    = redirect_tgt;
                        state_d = StFetch;
                    end else begin
                        valid     = 1'b1;
                        instr_raw = buf_instr_q;
                        if (accept_i) begin
                            if (is_halt(buf_instr_q)) begin
                                state_d = StHalted;
                            end else begin
                                pc_d    = pc_plus2;
                                state_d = StFetch;
                            end
                        end
                    end
                end
                StDrain: begin
                    imem_rd_o   = 1'b1;
                    imem_addr_o = drain_q;
                    if (redirect_i)  pc_d    = redirect_tgt;
                    if (imem_done_i) state_d = StFetch;
                end
                StHalted: begin
                    halted_o = 1'b1;
                    if (redirect_i) begin
                        pc_d    = redirect_tgt;
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    assign if_valid_o  = valid;
    assign if_bubble_o = !valid;
    assign if_instr_o  = valid ? instr_raw : NOP_INSTR;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            drain_q     <= 16'h0000;
            buf_instr_q <= 16'h0000;
            buf_pc2_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drain_q     <= drain_d;
            buf_instr_q <= buf_instr_d;
            buf_pc2_q   <= buf_pc2_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed multi-cycle sequences and
// a randomized run against an architectural PC/transfer model.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        accept = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        if_bubble;
    logic        halted;

    int checks = 0;
    int failures = 0;

    // Memory model: completes after a programmable number of wait cycles.
    int          cnt = 0;
    int          fixed_wait = 0;
    int          wait_cur = 0;
    logic        rand_mode = 1'b0;
    logic        ovr_en = 1'b0;
    logic [15:0] ovr_addr = 16'h0000;
    logic [15:0] ovr_data = 16'h0000;

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_addr_o  (imem_addr),
        .imem_rd_o    (imem_rd),
        .imem_done_i  (imem_done),
        .imem_data_i  (imem_data),
        .accept_i     (accept),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .if_valid_o   (if_valid),
        .if_instr_o   (if_instr),
        .if_pc_plus2_o(if_pc_plus2),
        .if_bubble_o  (if_bubble),
        .halted_o     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {1'b1, a[15:1]};  // top bit set: never a HALT
    endfunction

    always_comb begin
        imem_done = imem_rd && (cnt == (rand_mode ? wait_cur : fixed_wait));
        imem_data = (ovr_en && imem_addr == ovr_addr) ? ovr_data : mem_word(imem_addr);
    end

    always @(posedge clk) begin
        if (rst || !imem_rd || imem_done) begin
            cnt      <= 0;
            wait_cur <= $urandom_range(0, 3);
        end else begin
            cnt <= cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic a, input logic rd_in, input logic [15:0] rpc);
        @(negedge clk);
        rst = r;
        accept = a;
        redirect = rd_in;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    typedef struct {
        logic        rst;
        logic        acc;
        logic        red;
        logic [15:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc2;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic found;
        logic [15:0] exp_pc;
        logic        pend;
        logic [15:0] pend_addr;
        int          transfers;

        // Zero-wait memory sequence: streaming, HELD, redirects (incl. odd target, wrap).
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, NOP,      16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h8000, 16'h0002};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h8001, 16'h0004};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h8002, 16'h0006};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h8003, 16'h0008};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8003, 16'h0008};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8003, 16'h0008};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0008, 1'b0, NOP,      16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b1, 16'hFFFF, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h8000, 16'h0002};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h8001, 16'h0004};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, NOP,      16'h0000};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h8020, 16'h0042};

        fixed_wait = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].rst, vecs[i].acc, vecs[i].red, vecs[i].rpc);
            chk($sformatf("vec%0d_rd", i), 16'(imem_rd), 16'(vecs[i].e_rd));
            if (vecs[i].e_rd) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 16'(if_valid), 16'(vecs[i].e_valid));
            chk($sformatf("vec%0d_bubble", i), 16'(if_bubble), 16'(!vecs[i].e_valid));
            chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].e_instr);
            if (vecs[i].e_valid || vecs[i].rst)
                chk($sformatf("vec%0d_pc2", i), if_pc_plus2, vecs[i].e_pc2);
            chk($sformatf("vec%0d_halted", i), 16'(halted), 16'h0);
        end

        // Three cycles of request per fetch.
        fixed_wait = 2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0);
            chk("lat_rd", 16'(imem_rd), 16'h1);
            chk("lat_addr", imem_addr, 16'h0000);
            chk("lat_valid", 16'(if_valid), 16'(k == 2));
            if (k == 2) chk("lat_pc2", if_pc_plus2, 16'h0002);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("lat_next_rd", 16'(imem_rd), 16'h1);
        chk("lat_next_addr", imem_addr, 16'h0002);

        // Redirect one cycle into a request at 0x0008.
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0);
            if (if_valid && if_pc_plus2 == 16'h0008) found = 1'b1;
        end
        chk("drain_reach8", 16'(found), 16'h1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("drain_a0", imem_addr, 16'h0008);
        chk("drain_v0", 16'(if_valid), 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0040);
        chk("drain_a1", imem_addr, 16'h0008);
        chk("drain_v1", 16'(if_valid), 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("drain_rd2", 16'(imem_rd), 16'h1);
        chk("drain_a2", imem_addr, 16'h0008);
        chk("drain_v2", 16'(if_valid), 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("drain_new_addr", imem_addr, 16'h0040);
        found = if_valid;
        for (int k = 0; k < 10 && !found; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0);
            found = if_valid;
        end
        chk("drain_new_valid", 16'(found), 16'h1);
        chk("drain_new_pc2", if_pc_plus2, 16'h0042);

        // Back-pressure holds 0x1234 in the buffer.
        fixed_wait = 0;
        ovr_en = 1'b1;
        ovr_addr = 16'h0002;
        ovr_data = 16'h1234;
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
        chk("held_first", if_instr, 16'h1234);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0);
            chk("held_rd", 16'(imem_rd), 16'h0);
            chk("held_valid", 16'(if_valid), 16'h1);
            chk("held_instr", if_instr, 16'h1234);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("held_xfer", if_instr, 16'h1234);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("held_next_rd", 16'(imem_rd), 16'h1);
        chk("held_next_addr", imem_addr, 16'h0004);

        // HALT at 0x0004, then resume with a redirect.
        ovr_addr = 16'h0004;
        ovr_data = 16'h0000;
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("halt_valid", 16'(if_valid), 16'h1);
        chk("halt_instr", if_instr, 16'h0000);
        chk("halt_pc2", if_pc_plus2, 16'h0006);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0);
            chk("halt_halted", 16'(halted), 16'h1);
            chk("halt_rd", 16'(imem_rd), 16'h0);
            chk("halt_valid0", 16'(if_valid), 16'h0);
        end
        cyc(1'b0, 1'b1, 1'b1, 16'h0010);
        chk("halt_redir_valid", 16'(if_valid), 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("resume_halted", 16'(halted), 16'h0);
        chk("resume_addr", imem_addr, 16'h0010);
        chk("resume_valid", 16'(if_valid), 16'h1);
        chk("resume_pc2", if_pc_plus2, 16'h0012);
        ovr_en = 1'b0;

        // Reset while draining.
        fixed_wait = 3;
        do_reset();
        cyc(1'b0, 1'b1, 1'b1, 16'h0020);
        chk("rstd_valid", 16'(if_valid), 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("rstd_drain_addr", imem_addr, 16'h0000);
        chk("rstd_drain_rd", 16'(imem_rd), 16'h1);
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        chk("rstd_rd", 16'(imem_rd), 16'h0);
        chk("rstd_valid_r", 16'(if_valid), 16'h0);
        chk("rstd_instr", if_instr, NOP);
        chk("rstd_pc2", if_pc_plus2, 16'h0000);
        chk("rstd_halted", 16'(halted), 16'h0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0);
        chk("rstd_restart_rd", 16'(imem_rd), 16'h1);
        chk("rstd_restart_addr", imem_addr, 16'h0000);

        // Randomized run against an architectural model of the transferred stream.
        rand_mode = 1'b1;
        do_reset();
        exp_pc = 16'h0000;
        pend = 1'b0;
        pend_addr = 16'h0000;
        transfers = 0;
        for (int k = 0; k < 3000; k++) begin
            logic        a, r;
            logic [15:0] t;
            a = ($urandom % 4) != 0;
            r = ($urandom % 16) == 0;
            t = 16'($urandom);
            cyc(1'b0, a, r, t);
            if (if_bubble !== !if_valid) chk("rnd_bubble", 16'(if_bubble), 16'(!if_valid));
            if (!if_valid) begin
                if (if_instr !== NOP) chk("rnd_nop", if_instr, NOP);
            end
            if (pend) begin
                chk("rnd_rd_hold", 16'(imem_rd), 16'h1);
                chk("rnd_addr_hold", imem_addr, pend_addr);
            end
            if (r) begin
                chk("rnd_redir_valid", 16'(if_valid), 16'h0);
                exp_pc = {t[15:1], 1'b0};
            end else if (if_valid) begin
                chk("rnd_pc2", if_pc_plus2, exp_pc + 16'd2);
                chk("rnd_instr", if_instr, mem_word(exp_pc));
                if (a) begin
                    exp_pc = exp_pc + 16'd2;
                    transfers++;
                end
            end
            pend = imem_rd && !imem_done;
            pend_addr = imem_addr;
        end
        chk("rnd_progress", 16'(transfers > 300), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipeline, directly upstream of the IF/ID register. Owns the PC and drives a variable-latency instruction-memory handshake. Presents one instruction plus its PC+2 per cycle to IF/ID and holds it stable until the hazard unit accepts it. Handles branch/jump redirects, including abandoning a request already in flight, and stops fetching after a HALT.

## Interface
- `RESET_PC`, default `16'h0000`: PC value loaded on reset.
- `NOP_INSTR`, default `16'h0800`: instruction driven when no valid instruction is presented.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  16  instruction memory address.
- `imem_rd`  out  1  read request, level; held with stable `imem_addr` until `imem_done`.
- `imem_done`  in  1  read complete; may assert in the same cycle `imem_rd` first rises.
- `imem_data`  in  16  instruction; valid only while `imem_done`=1.
- `accept`  in  1  IF/ID write enable from the hazard unit; transfer occurs when `if_valid && accept`.
- `redirect`  in  1  taken branch/jump pulse from a later stage.
- `redirect_pc`  in  16  target address; bit 0 is forced to 0.
- `if_valid`  out  1  `if_instr`/`if_pc_plus2` hold a real instruction.
- `if_instr`  out  16  instruction, or `NOP_INSTR` when `!if_valid`.
- `if_pc_plus2`  out  16  fetch address + 2, modulo 2^16.
- `if_bubble`  out  1  equals `!if_valid`; feeds the IF/ID stall input.
- `halted`  out  1  high while in HALTED.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `drain_addr`: address of an abandoned in-flight request.
  - `buf_instr` / `buf_pc2`: held instruction and its PC+2.
  - `state`: one of FETCH, HELD, DRAIN, HALTED.
- FETCH: drive `imem_rd`=1 and `imem_addr`=`pc`.
  - `imem_done && !redirect`: drive `if_valid`=1, `if_instr`=`imem_data`, `if_pc_plus2`=`pc`+2.
    - With `accept`: `pc` <= `pc`+2 and stay in FETCH. This gives 1 instruction per cycle on zero-wait memory.
    - Without `accept`: capture the instruction into the buffers and go to HELD.
  - No `imem_done`: `if_valid`=0 and stay in FETCH.
- HELD: `imem_rd`=0; outputs come from the buffers with `if_valid`=1. On `accept`: `pc` <= `pc`+2 and go to FETCH.
- Redirect has highest priority in every state.
  - `pc` <= `redirect_pc`, and `if_valid` is forced to 0 combinationally in the redirect cycle.
  - FETCH with `imem_done`=1 that cycle: discard the data and stay in FETCH.
  - FETCH with `imem_done`=0: `drain_addr` <= `pc` and go to DRAIN.
  - HELD: drop the buffer and go to FETCH.
  - DRAIN: update `pc` and stay in DRAIN.
  - HALTED: go to FETCH.
- DRAIN: `imem_rd`=1 and `imem_addr`=`drain_addr`; `if_valid`=0. On `imem_done`, discard the data and go to FETCH with the new `pc`.
- HALT: opcode bits [15:11]=5'b00000. When a HALT is transferred (`if_valid && accept`):
  - go to HALTED; `pc` does not advance;
  - in HALTED, `imem_rd`=0 and `if_valid`=0;
  - leave HALTED only on `redirect` or `rst`.
- Arithmetic: `pc`+2 is a 16-bit add that wraps; 0xFFFE+2 = 0x0000. No misalignment checks beyond forcing bit 0 of the redirect target.

## Timing
- Reset values: `pc`=`RESET_PC`, state=FETCH, buffers cleared.
  - During the `rst`=1 cycle: `imem_rd`=0, `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc_plus2`=0, `halted`=0.
  - The first request is issued in the first cycle after `rst` deasserts.
  - Reset mid-DRAIN or mid-request abandons it unconditionally; memory is reset by the same `rst`.
- Latency:
  - Memory latency N≥0 cycles gives `if_valid` N cycles after `imem_rd` rises.
  - Throughput is 1/(N+1) without back-pressure.
- `imem_addr` never changes while `imem_rd`=1 and `imem_done`=0.
- Simultaneous events:
  - `redirect` with `imem_done` and `accept`: redirect wins; nothing is transferred.
  - `redirect` in HELD with `accept`: nothing is transferred.
  - HALT with `accept`=0: go to HELD; HALTED is entered only on transfer.

## Test plan
- Reset, then zero-wait memory (`imem_done` tied to `imem_rd`), `accept`=1: `imem_addr` is 0,2,4 on consecutive cycles; `if_pc_plus2` is 2,4,6; `if_bubble`=0 from the first cycle after reset.
- 3-cycle memory latency: `imem_rd` is high for 3 cycles at 0x0000 with stable address; `if_valid` pulses once with `if_pc_plus2`=0x0002; the next request is at 0x0002.
- `accept`=0 when data 0x1234 returns: HELD, `imem_rd`=0, `if_instr` holds 0x1234 for 4 cycles. After `accept`, the next fetch is at `pc`+2.
- `redirect` to 0x0040 one cycle into a 3-cycle request at 0x0008:
  - `imem_addr` stays 0x0008 until done;
  - its data is never valid;
  - the next request is at 0x0040 and yields `if_pc_plus2`=0x0042.
- HALT (0x0000) fetched at 0x0004 and accepted: `halted`=1, no `imem_rd` for 10 cycles. `redirect` to 0x0010 resumes fetching at 0x0010.
- Redirect to 0xFFFE: `if_pc_plus2`=0x0000 and the next fetch is at 0x0000. Assert `rst` during a DRAIN: the next cycle shows reset values, and fetch restarts at `RESET_PC`.
